imem_fetch_responder: RTL

IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

---
 rtl/core_pkg.sv | 15 +
 rtl/imem_fetch_responder_resp_fifo2.sv | 54 +++++
 rtl/imem_fetch_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, NOP encoding and the response entry type.
package core_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

   // One queued fetch response
   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            err;
   } resp_entry_t;

endpackage

// File: rtl/imem_fetch_responder_resp_fifo2.sv
// Two-entry in-order response FIFO used by imem_fetch_responder.
module resp_fifo2
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_push,
   input  resp_entry_t i_push_entry,
   input  logic        i_pop,
   output resp_entry_t o_head,
   output logic [1:0]  o_count,
   output logic        o_full,
   output logic        o_empty
);

   resp_entry_t r_slot [2];
   logic        r_wptr;
   logic        r_rptr;
   logic [1:0]  r_count;

   logic        w_do_push;
   logic        w_do_pop;

   assign w_do_push = i_push && (r_count != 2'd2);
   assign w_do_pop  = i_pop  && (r_count != 2'd0);

   // Pointer and occupancy tracking; push and pop may happen together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_do_push) r_wptr <= ~r_wptr;
         if (w_do_pop)  r_rptr <= ~r_rptr;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied
   always_ff @(posedge clk) begin
      if (w_do_push) r_slot[r_wptr] <= i_push_entry;
   end

   assign o_head  = r_slot[r_rptr];
   assign o_count = r_count;
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory fetch responder: registered word read behind a
// valid/ready request port, 2-entry response FIFO, loader write port.
// Optional misaligned-fetch fault: define IMEM_MISALIGN_CHECK_EN.
module imem_fetch_responder
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_addr,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_err,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] r_mem [DEPTH];
   logic            r_inflight;
   logic [XLEN-1:0] r_rd_data;
   logic            r_rd_err;

   logic [AW-1:0]   w_rd_idx;
   logic            w_misaligned;
   logic            w_accept;
   logic            w_fifo_push;
   logic            w_fifo_pop;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic [1:0]      w_fifo_count;
   resp_entry_t     w_fifo_head;
   resp_entry_t     w_rd_entry;
   resp_entry_t     w_resp_entry;
   logic            w_unused_bits;

   // Upper address bits are dropped, so fetches wrap modulo 4*DEPTH
   assign w_rd_idx = req_addr[AW+1:2];

`ifdef IMEM_MISALIGN_CHECK_EN
   assign w_misaligned  = (req_addr[1:0] != 2'b00);
   assign resp_err      = w_resp_entry.err;
   assign w_unused_bits = ^{req_addr[31:AW+2], w_fifo_full};
`else
   assign w_misaligned  = 1'b0;
   assign resp_err      = 1'b0;
   assign w_unused_bits = ^{req_addr[31:AW+2], req_addr[1:0], w_fifo_full, w_resp_entry.err};
`endif

   // Credit check from registered state only: queued plus in-flight must leave room
   assign req_ready = !rst && (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2);
   assign w_accept  = req_valid && req_ready;

   // Loader write and registered fetch read; a same-index read sees the old word
   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
      if (w_accept) begin
         r_rd_data <= w_misaligned ? NOP_INSN : r_mem[w_rd_idx];
         r_rd_err  <= w_misaligned;
      end
   end

   // One read in flight for the cycle after each acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_inflight <= 1'b0;
      else     r_inflight <= w_accept;
   end

   assign w_rd_entry.data = r_rd_data;
   assign w_rd_entry.err  = r_rd_err;

   // The completing read is presented straight from the read register when the
   // FIFO is empty; it only enters the FIFO if the consumer does not take it.
   assign w_fifo_pop  = !w_fifo_empty && resp_ready;
   assign w_fifo_push = r_inflight && !(w_fifo_empty && resp_ready);

   resp_fifo2 u_resp_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_fifo_push),
      .i_push_entry (w_rd_entry),
      .i_pop        (w_fifo_pop),
      .o_head       (w_fifo_head),
      .o_count      (w_fifo_count),
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty)
   );

   // Response head: oldest queued entry first, else the completing read, else zero
   always_comb begin
      w_resp_entry = '0;
      if (!w_fifo_empty)   w_resp_entry = w_fifo_head;
      else if (r_inflight) w_resp_entry = w_rd_entry;
   end

   assign resp_valid = !w_fifo_empty || r_inflight;
   assign resp_data  = w_resp_entry.data;

endmodule
